pcie_rst_seq: RTL and testbench
===============================

PCIE_RST_SEQ -- requirements
Module: pcie_rst_seq

Interface
REQ-001 SHALL have parameter HOLD_CYCLES, default 500: sys_clk cycles all resets are held low after reset or restart.
REQ-002 SHALL have parameter POR_TO_PERST, default 16: cycles from POR release to PERST# release.
REQ-003 SHALL have parameter LINK_TIMEOUT, default 100000: cycles allowed in WAIT_LINK before a timeout.
REQ-004 SHALL have parameter MAX_RETRY, default 3: number of timeout-triggered retries before FAIL.
REQ-005 SHALL have parameter CNT_W, default 20: counter width; every cycle parameter above SHALL be less than 2^CNT_W.
REQ-006 sys_clk  input  1  single clock; all logic on rising edge.
REQ-007 sys_rst_n  input  1  synchronous, active-low reset.
REQ-008 restart  input  1  one-cycle request to re-run the full sequence.
REQ-009 link_up  input  1  link-up status, synchronous to sys_clk.
REQ-010 por_n  output  1  POR release to PS-VIP and CPM.
REQ-011 perst_n  output  1  PERST0N/PERST1N drive.
REQ-012 link_ok  output  1  high while in LINK_UP.
REQ-013 timeout  output  1  sticky flag, set on entry to FAIL.
REQ-014 retry_cnt  output  2  number of retries taken.
REQ-015 state  output  3  encoding: HOLD=0, POR_REL=1, WAIT_LINK=2, LINK_UP=3, FAIL=4.

Function
REQ-016 SHALL be a Moore FSM; outputs SHALL be registered and SHALL change on the same edge as state.
REQ-017 HOLD: por_n=0, perst_n=0; cnt increments each cycle; at cnt==HOLD_CYCLES-1 SHALL go to POR_REL with cnt=0.
REQ-018 POR_REL: por_n=1, perst_n=0; at cnt==POR_TO_PERST-1 SHALL go to WAIT_LINK with cnt=0.
REQ-019 WAIT_LINK: por_n=1, perst_n=1; cnt increments; link_up==1 SHALL go to LINK_UP on the next edge.
REQ-020 Watchdog (REQ-030): at cnt==LINK_TIMEOUT-1 with link_up==0, SHALL go to HOLD with retry_cnt+1 if retry_cnt<MAX_RETRY, else go to FAIL.
REQ-021 If link_up==1 and cnt==LINK_TIMEOUT-1 in the same cycle, link_up SHALL win.
REQ-022 LINK_UP: link_ok=1, por_n=1, perst_n=1; link_up==0 SHALL return to WAIT_LINK with cnt=0, link_ok=0, and retry_cnt unchanged.
REQ-023 FAIL: por_n=1, perst_n=0, timeout=1; SHALL remain in FAIL until restart or reset.
REQ-024 restart==1 in any state SHALL go to HOLD with cnt=0, retry_cnt=0, timeout=0, and all reset outputs low; restart SHALL win over every simultaneous event.
REQ-025 The counter SHALL never wrap; it SHALL clear on every state transition.

Reset
REQ-026 On sys_rst_n==0 at a sys_clk edge: state=HOLD, cnt=0, retry_cnt=0, por_n=0, perst_n=0, link_ok=0, timeout=0.
REQ-027 Reset asserted mid-sequence SHALL abort immediately; no output glitches high during reset.
REQ-028 After sys_rst_n deasserts, por_n SHALL rise exactly HOLD_CYCLES edges later.

Configuration
REQ-029 Macro PCIE_RST_SEQ_LINK_WDOG_EN SHALL control the watchdog.
REQ-030 With PCIE_RST_SEQ_LINK_WDOG_EN defined: REQ-020 and REQ-023 are active.
REQ-031 Without PCIE_RST_SEQ_LINK_WDOG_EN: WAIT_LINK waits indefinitely, the cnt in WAIT_LINK holds at 0, FAIL is unreachable, and timeout and retry_cnt are tied 0.

Verification
Bench parameters for all scenarios: HOLD_CYCLES=8, POR_TO_PERST=4, LINK_TIMEOUT=20, MAX_RETRY=2.
REQ-032 Release sys_rst_n, then raise link_up at edge 20 -> por_n rises at edge 8, perst_n at edge 12, link_ok at edge 21, state=3.
REQ-033 Hold link_up=0 (watchdog enabled) -> perst_n drops at edge 32 and retry_cnt=1; after the 2nd retry, next timeout enters FAIL with timeout=1, por_n=1, perst_n=0.
REQ-034 In LINK_UP, drop link_up for one cycle -> link_ok=0, state=2, cnt restarts, retry_cnt unchanged; link_up high again -> link_ok=1 next edge.
REQ-035 In FAIL, pulse restart together with link_up=1 -> state=0, timeout=0, retry_cnt=0, por_n=0; por_n rises 8 edges later.
REQ-036 Assert sys_rst_n=0 at edge 10 (inside POR_REL) -> next edge: por_n=0, perst_n=0, state=0.
REQ-037 Build without the macro, link_up=0 for 1000 cycles -> state stays 2, timeout=0, retry_cnt=0.

Source files
------------

// File: rtl/pcie_rst_seq.sv
// PCIe reset sequencer: holds POR/PERST# low, releases POR then PERST#, then waits for link-up.
// Outputs are registered with the state. Define PCIE_RST_SEQ_LINK_WDOG_EN for the link-up watchdog, retries and FAIL state.
module pcie_rst_seq #(
  parameter int unsigned HOLD_CYCLES  = 500,
  parameter int unsigned POR_TO_PERST = 16,
  parameter int unsigned LINK_TIMEOUT = 100000,
  parameter int unsigned MAX_RETRY    = 3,
  parameter int unsigned CNT_W        = 20
) (
  input  logic       sys_clk,
  input  logic       sys_rst_n,
  input  logic       restart,
  input  logic       link_up,
  output logic       por_n,
  output logic       perst_n,
  output logic       link_ok,
  output logic       timeout,
  output logic [1:0] retry_cnt,
  output logic [2:0] state
);

  typedef enum logic [2:0] {
    ST_HOLD      = 3'd0,
    ST_POR_REL   = 3'd1,
    ST_WAIT_LINK = 3'd2,
    ST_LINK_UP   = 3'd3,
    ST_FAIL      = 3'd4
  } st_t;

  localparam logic [CNT_W-1:0] LP_HOLD_LAST = CNT_W'(HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] LP_POR_LAST  = CNT_W'(POR_TO_PERST - 1);

  // Every cycle count must fit the counter; retry_cnt is only 2 bits wide.
  if (((64'(HOLD_CYCLES) >> CNT_W) != 0) || ((64'(POR_TO_PERST) >> CNT_W) != 0) ||
      ((64'(LINK_TIMEOUT) >> CNT_W) != 0) || (HOLD_CYCLES == 0) || (POR_TO_PERST == 0) ||
      (LINK_TIMEOUT == 0) || (MAX_RETRY > 3)) begin : g_bad_cfg
    $error("pcie_rst_seq: parameter out of range");
  end

  st_t              r_state;
  logic [CNT_W-1:0] r_cnt;
  logic             r_por_n;
  logic             r_perst_n;
  logic             r_link_ok;

  st_t              w_nxt_state;
  logic             w_cnt_inc;
  logic [CNT_W-1:0] w_cnt_nxt;

`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
  localparam logic [CNT_W-1:0] LP_LINK_LAST = CNT_W'(LINK_TIMEOUT - 1);
  localparam logic [1:0]       LP_MAX_RETRY = 2'(MAX_RETRY);

  logic [1:0] r_retry;
  logic       r_timeout;
  logic [1:0] w_retry_nxt;
`endif

  always_comb begin
    w_nxt_state = r_state;
    w_cnt_inc   = 1'b0;
`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
    w_retry_nxt = r_retry;
`endif
    case (r_state)
      ST_HOLD: begin
        if (r_cnt == LP_HOLD_LAST) w_nxt_state = ST_POR_REL;
        else                       w_cnt_inc   = 1'b1;
      end
      ST_POR_REL: begin
        if (r_cnt == LP_POR_LAST) w_nxt_state = ST_WAIT_LINK;
        else                      w_cnt_inc   = 1'b1;
      end
      ST_WAIT_LINK: begin
        // Link-up takes priority over a coincident watchdog expiry.
        if (link_up) begin
          w_nxt_state = ST_LINK_UP;
`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
        end else if (r_cnt == LP_LINK_LAST) begin
          if (r_retry < LP_MAX_RETRY) begin
            w_nxt_state = ST_HOLD;
            w_retry_nxt = r_retry + 2'd1;
          end else begin
            w_nxt_state = ST_FAIL;
          end
        end else begin
          w_cnt_inc = 1'b1;
`endif
        end
      end
      ST_LINK_UP: begin
        if (!link_up) w_nxt_state = ST_WAIT_LINK;
      end
      ST_FAIL: begin
        w_nxt_state = ST_FAIL;
      end
      default: begin
        w_nxt_state = ST_HOLD;
      end
    endcase

    if (restart) begin
      w_nxt_state = ST_HOLD;
`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
      w_retry_nxt = 2'd0;
`endif
    end

    // Counter clears on every transition (and on restart) and saturates instead of wrapping.
    if (restart || (w_nxt_state != r_state)) w_cnt_nxt = '0;
    else if (w_cnt_inc && (r_cnt != '1))     w_cnt_nxt = r_cnt + CNT_W'(1);
    else                                     w_cnt_nxt = r_cnt;
  end

  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_state   <= ST_HOLD;
      r_cnt     <= '0;
      r_por_n   <= 1'b0;
      r_perst_n <= 1'b0;
      r_link_ok <= 1'b0;
    end else begin
      r_state   <= w_nxt_state;
      r_cnt     <= w_cnt_nxt;
      r_por_n   <= (w_nxt_state != ST_HOLD);
      r_perst_n <= (w_nxt_state == ST_WAIT_LINK) || (w_nxt_state == ST_LINK_UP);
      r_link_ok <= (w_nxt_state == ST_LINK_UP);
    end
  end

`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
  always_ff @(posedge sys_clk) begin
    if (!sys_rst_n) begin
      r_retry   <= 2'd0;
      r_timeout <= 1'b0;
    end else begin
      r_retry   <= w_retry_nxt;
      // FAIL is left only through restart or reset, so the flag tracks the state.
      r_timeout <= (w_nxt_state == ST_FAIL);
    end
  end

  assign retry_cnt = r_retry;
  assign timeout   = r_timeout;
`else
  assign retry_cnt = 2'd0;
  assign timeout   = 1'b0;
`endif

  assign por_n   = r_por_n;
  assign perst_n = r_perst_n;
  assign link_ok = r_link_ok;
  assign state   = r_state;

endmodule

// File: tb/tb_pcie_rst_seq.sv
// Bench for pcie_rst_seq: vector table plus hand sequences, expectations queued and checked at negedge.
module tb_pcie_rst_seq;

  logic       sys_clk   = 1'b0;
  logic       sys_rst_n = 1'b0;
  logic       restart   = 1'b0;
  logic       link_up   = 1'b0;
  logic       por_n;
  logic       perst_n;
  logic       link_ok;
  logic       timeout;
  logic [1:0] retry_cnt;
  logic [2:0] state;

  int checks   = 0;
  int failures = 0;

  typedef struct packed {
    logic       por_n;
    logic       perst_n;
    logic       link_ok;
    logic       timeout;
    logic [1:0] retry;
    logic [2:0] st;
  } out_t;

  typedef struct {
    logic  rst_n;
    logic  restart;
    logic  link_up;
    int    n;
    out_t  exp;
    string name;
  } vec_t;

  out_t  sb_q[$];
  string nm_q[$];
  vec_t  vt[$];

  pcie_rst_seq #(
    .HOLD_CYCLES (8),
    .POR_TO_PERST(4),
    .LINK_TIMEOUT(20),
    .MAX_RETRY   (2),
    .CNT_W       (8)
  ) dut (
    .sys_clk  (sys_clk),
    .sys_rst_n(sys_rst_n),
    .restart  (restart),
    .link_up  (link_up),
    .por_n    (por_n),
    .perst_n  (perst_n),
    .link_ok  (link_ok),
    .timeout  (timeout),
    .retry_cnt(retry_cnt),
    .state    (state)
  );

  always #5 sys_clk = ~sys_clk;

  function automatic out_t o(input logic p, input logic pe, input logic ok,
                             input logic to, input logic [1:0] r, input logic [2:0] s);
    out_t v;
    v = {p, pe, ok, to, r, s};
    return v;
  endfunction

  function automatic vec_t mkv(input logic rn, input logic rs, input logic lu, input int n,
                               input out_t e, input string name);
    vec_t v;
    v.rst_n = rn; v.restart = rs; v.link_up = lu; v.n = n; v.exp = e; v.name = name;
    return v;
  endfunction

  task automatic check_out();
    out_t  a;
    out_t  e;
    string nm;
    a  = {por_n, perst_n, link_ok, timeout, retry_cnt, state};
    e  = sb_q.pop_front();
    nm = nm_q.pop_front();
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got por=%b perst=%b ok=%b to=%b retry=%0d state=%0d, want por=%b perst=%b ok=%b to=%b retry=%0d state=%0d",
               nm, a.por_n, a.perst_n, a.link_ok, a.timeout, a.retry, a.st,
               e.por_n, e.perst_n, e.link_ok, e.timeout, e.retry, e.st);
    end
  endtask

  // Inputs change at a negedge, run n rising edges, compare at the following negedge.
  task automatic drive(input logic rn, input logic rs, input logic lu, input int n,
                       input out_t e, input string name);
    sys_rst_n = rn;
    restart   = rs;
    link_up   = lu;
    sb_q.push_back(e);
    nm_q.push_back(name);
    repeat (n) @(posedge sys_clk);
    @(negedge sys_clk);
    check_out();
  endtask

  initial begin
    // Release sequence, link up at edge 21, link bounce, restart from LINK_UP.
    vt.push_back(mkv(0, 0, 0, 3, o(0, 0, 0, 0, 0, 0), "reset_state"));
    vt.push_back(mkv(1, 0, 0, 7, o(0, 0, 0, 0, 0, 0), "hold_edge7"));
    vt.push_back(mkv(1, 0, 0, 1, o(1, 0, 0, 0, 0, 1), "por_edge8"));
    vt.push_back(mkv(1, 0, 0, 3, o(1, 0, 0, 0, 0, 1), "porrel_edge11"));
    vt.push_back(mkv(1, 0, 0, 1, o(1, 1, 0, 0, 0, 2), "perst_edge12"));
    vt.push_back(mkv(1, 0, 0, 8, o(1, 1, 0, 0, 0, 2), "wait_edge20"));
    vt.push_back(mkv(1, 0, 1, 1, o(1, 1, 1, 0, 0, 3), "linkup_edge21"));
    vt.push_back(mkv(1, 0, 0, 1, o(1, 1, 0, 0, 0, 2), "link_drop"));
    vt.push_back(mkv(1, 0, 1, 1, o(1, 1, 1, 0, 0, 3), "link_back"));
    vt.push_back(mkv(1, 0, 1, 5, o(1, 1, 1, 0, 0, 3), "link_steady"));
    vt.push_back(mkv(1, 1, 1, 1, o(0, 0, 0, 0, 0, 0), "restart_linkup"));
    vt.push_back(mkv(1, 0, 0, 7, o(0, 0, 0, 0, 0, 0), "restart_hold7"));
    vt.push_back(mkv(1, 0, 0, 1, o(1, 0, 0, 0, 0, 1), "restart_por8"));
    vt.push_back(mkv(1, 0, 0, 3, o(1, 0, 0, 0, 0, 1), "restart_porrel"));
    vt.push_back(mkv(1, 0, 0, 1, o(1, 1, 0, 0, 0, 2), "restart_perst12"));

    foreach (vt[i]) drive(vt[i].rst_n, vt[i].restart, vt[i].link_up, vt[i].n, vt[i].exp, vt[i].name);

`ifdef PCIE_RST_SEQ_LINK_WDOG_EN
    // Watchdog: two retries, then FAIL; restart wins over link_up.
    drive(1, 0, 0, 19, o(1, 1, 0, 0, 0, 2), "wdog_edge31");
    drive(1, 0, 0, 1,  o(0, 0, 0, 0, 1, 0), "wdog_retry1");
    drive(1, 0, 0, 32, o(0, 0, 0, 0, 2, 0), "wdog_retry2");
    drive(1, 0, 0, 31, o(1, 1, 0, 0, 2, 2), "wdog_last_wait");
    drive(1, 0, 0, 1,  o(1, 0, 0, 1, 2, 4), "wdog_fail");
    drive(1, 0, 1, 10, o(1, 0, 0, 1, 2, 4), "fail_sticky");
    drive(1, 1, 1, 1,  o(0, 0, 0, 0, 0, 0), "fail_restart");
    drive(1, 0, 0, 7,  o(0, 0, 0, 0, 0, 0), "fail_restart_hold7");
    drive(1, 0, 0, 1,  o(1, 0, 0, 0, 0, 1), "fail_restart_por8");
    drive(1, 0, 0, 3,  o(1, 0, 0, 0, 0, 1), "tie_porrel");
    drive(1, 0, 0, 1,  o(1, 1, 0, 0, 0, 2), "tie_wait");
    drive(1, 0, 0, 19, o(1, 1, 0, 0, 0, 2), "tie_edge31");
    drive(1, 0, 1, 1,  o(1, 1, 1, 0, 0, 3), "tie_linkup_wins");
`else
    // No watchdog: WAIT_LINK holds indefinitely.
    for (int k = 0; k < 10; k++) drive(1, 0, 0, 100, o(1, 1, 0, 0, 0, 2), "nowdog_wait");
`endif

    // Reset asserted inside POR_REL aborts at once and stays low; por_n rises 8 edges after release.
    drive(0, 0, 0, 2, o(0, 0, 0, 0, 0, 0), "rst_again");
    drive(1, 0, 0, 9, o(1, 0, 0, 0, 0, 1), "rst_edge9_porrel");
    drive(0, 0, 0, 1, o(0, 0, 0, 0, 0, 0), "rst_edge10_abort");
    drive(0, 0, 1, 3, o(0, 0, 0, 0, 0, 0), "rst_held_low");
    for (int k = 1; k <= 8; k++) begin
      if (k == 8) drive(1, 0, 0, 1, o(1, 0, 0, 0, 0, 1), "rel_por_edge8");
      else        drive(1, 0, 0, 1, o(0, 0, 0, 0, 0, 0), "rel_hold_edge");
    end

    if (sb_q.size() != 0) begin
      checks++;
      failures++;
      $display("FAIL scoreboard_drain: got %0d pending, want 0", sb_q.size());
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
